// File: rtl/mux_81.sv
// Eight-to-one single-bit multiplexer with a combinational output and a
// registered copy of the selected bit and select code, plus a valid flag.
module mux_81 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       D0,
   input  logic       D1,
   input  logic       D2,
   input  logic       D3,
   input  logic       D4,
   input  logic       D5,
   input  logic       D6,
   input  logic       D7,
   input  logic [2:0] sel,
   output logic       out,
   output logic       out_q,
   output logic [2:0] sel_q,
   output logic       out_vld
);

   // NOTE: out is assigned on every path (default first, then a full case with
   // a default arm), so no latch is inferred; an X/Z select falls to the default.
   always_comb begin
      out = 1'b0;
      case (sel)
         3'd0:    out = D0;
         3'd1:    out = D1;
         3'd2:    out = D2;
         3'd3:    out = D3;
         3'd4:    out = D4;
         3'd5:    out = D5;
         3'd6:    out = D6;
         3'd7:    out = D7;
         default: out = 1'b0;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge value of out and sel together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= 1'b0;
         sel_q   <= 3'b000;
         out_vld <= 1'b0;
      end else begin
         out_q   <= out;
         sel_q   <= sel;
         out_vld <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_81.sv
// Directed self-checking bench for mux_81: combinational selection, isolation,
// walking patterns, asynchronous reset, reset release and X on the select.
module tb_mux_81;

   logic       clk;
   logic       rst_n;
   logic [7:0] d;
   logic [2:0] sel;
   logic       out;
   logic       out_q;
   logic [2:0] sel_q;
   logic       out_vld;

   int checks;
   int errors;

   mux_81 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .D0      (d[0]),
      .D1      (d[1]),
      .D2      (d[2]),
      .D3      (d[3]),
      .D4      (d[4]),
      .D5      (d[5]),
      .D6      (d[6]),
      .D7      (d[7]),
      .sel     (sel),
      .out     (out),
      .out_q   (out_q),
      .sel_q   (sel_q),
      .out_vld (out_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n = 1'b0;
      d     = 8'b0000_0100;
      sel   = 3'd2;
      #3;
      checks++;
      if (out_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_q got=%b exp=0", out_q);
      end
      checks++;
      if (sel_q !== 3'd0) begin
         errors++;
         $display("FAIL reset_sel_q got=%0d exp=0", sel_q);
      end
      checks++;
      if (out_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_vld got=%b exp=0", out_vld);
      end
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL reset_out_comb got=%b exp=1", out);
      end
   endtask

   task automatic test_sel_sweep;
      logic [7:0] exp_pat;
      exp_pat = 8'b1000_1001;
      d       = 8'b1000_1001;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         #2;
         checks++;
         if (out !== exp_pat[i]) begin
            errors++;
            $display("FAIL sweep sel=%0d got=%b exp=%b", i, out, exp_pat[i]);
         end
      end
   endtask

   task automatic test_isolation;
      sel = 3'd3;
      d   = 8'b0000_1000;
      #1;
      for (int i = 0; i < 8; i++) begin
         if (i != 3) begin
            d[i] = ~d[i];
            #1;
            checks++;
            if (out !== 1'b1) begin
               errors++;
               $display("FAIL isolation toggle D%0d got=%b exp=1", i, out);
            end
         end
      end
      d[3] = 1'b0;
      #1;
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL isolation D3_low got=%b exp=0", out);
      end
   endtask

   task automatic test_walking;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         d   = 8'(1) << k;
         #1;
         checks++;
         if (out !== 1'b1) begin
            errors++;
            $display("FAIL walk_one k=%0d got=%b exp=1", k, out);
         end
         d = ~(8'(1) << k);
         #1;
         checks++;
         if (out !== 1'b0) begin
            errors++;
            $display("FAIL walk_zero k=%0d got=%b exp=0", k, out);
         end
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      rst_n = 1'b1;
      sel   = 3'd5;
      d     = 8'b0010_0000;
      @(negedge clk);
      checks++;
      if (out_q !== 1'b1 || sel_q !== 3'd5 || out_vld !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_load got=%b/%0d/%b exp=1/5/1", out_q, sel_q, out_vld);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_q !== 1'b0 || sel_q !== 3'd0 || out_vld !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0", out_q, sel_q, out_vld);
      end
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_out got=%b exp=1", out);
      end
      d[5] = 1'b0;
      #1;
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL in_reset_tracking got=%b exp=0", out);
      end
   endtask

   task automatic test_release;
      sel = 3'd7;
      d   = 8'b1000_0000;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_vld !== 1'b0) begin
         errors++;
         $display("FAIL vld_before_edge got=%b exp=0", out_vld);
      end
      @(negedge clk);
      checks++;
      if (out_q !== 1'b1 || sel_q !== 3'd7 || out_vld !== 1'b1) begin
         errors++;
         $display("FAIL release_load got=%b/%0d/%b exp=1/7/1", out_q, sel_q, out_vld);
      end
      sel  = 3'd0;
      d[0] = 1'b0;
      #1;
      checks++;
      if (out !== 1'b0 || out_q !== 1'b1) begin
         errors++;
         $display("FAIL sel_change_comb got out=%b out_q=%b exp out=0 out_q=1", out, out_q);
      end
      @(negedge clk);
      checks++;
      if (out_q !== 1'b0 || sel_q !== 3'd0) begin
         errors++;
         $display("FAIL sel_change_reg got=%b/%0d exp=0/0", out_q, sel_q);
      end
   endtask

   task automatic test_x_sel;
      d   = 8'b0000_0000;
      sel = 3'bxxx;
      #1;
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL x_sel got=%b exp=0", out);
      end
      d[7] = 1'b1;
      sel  = 3'd7;
      #1;
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL x_sel_restore got=%b exp=1", out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sel_sweep();
      test_isolation();
      test_walking();
      test_async_reset();
      test_release();
      test_x_sel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
